// File: rtl/instr_encoder.sv
// Encodes instruction requests into 16-bit words queued in a DEPTH-entry buffer with a word-address counter.
// Latency: 1 cycle minimum, no bypass. Backpressure: in_ready is registered-state only; a pop frees a slot on the next cycle.
module instr_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [2:0]        in_rs,
   input  logic [2:0]        in_rt,
   input  logic [2:0]        in_rd,
   input  logic [2:0]        in_funct,
   input  logic [5:0]        in_imm,
   input  logic [11:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [3:0]        err_count
);

   localparam int PW = $clog2(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          started;
   logic          full;
   logic          accept;
   logic          class_ok;
   logic          push;
   logic          pop;
   logic [3:0]    opcode;
   logic [15:0]   enc;

   // started keeps in_ready low until the first edge after reset release
   assign full      = (count == (PW+1)'(DEPTH));
   assign in_ready  = started & ~full;
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready & ~flush;
   assign class_ok  = (in_class < 3'd6);
   assign push      = accept & class_ok;
   assign pop       = out_valid & out_ready & ~flush;
   assign out_instr = out_valid ? mem[rd_ptr] : 16'h0000;

   always_comb begin
      opcode = 4'b0000;
      enc    = 16'h0000;
      case (in_class)
         3'd0: opcode = 4'b0000;
         3'd1: opcode = 4'b0100;
         3'd2: opcode = 4'b1011;
         3'd3: opcode = 4'b1111;
         3'd4: opcode = 4'b1000;
         3'd5: opcode = 4'b0010;
         default: opcode = 4'b0000;
      endcase
      case (in_class)
         3'd0:    enc = {opcode, in_rs, in_rt, in_rd, in_funct};
         3'd5:    enc = {opcode, in_target};
         default: enc = {opcode, in_rs, in_rt, in_imm};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         started   <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_addr  <= '0;
         err       <= 1'b0;
         err_count <= 4'd0;
      end else begin
         started <= 1'b1;
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
               rd_ptr   <= rd_ptr + 1'b1;
               out_addr <= out_addr + 1'b1;
            end
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (accept && !class_ok) begin
            err <= 1'b1;
            if (err_count != 4'd15) err_count <= err_count + 1'b1;
         end
      end
   end

   // storage carries no reset; out_instr is masked while the buffer is empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= enc;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, 8, width of the instruction-memory word address.
REQ-002 Parameter: DEPTH, 4, output buffer entries; power of two, minimum 2.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: flush  in  1  synchronous clear of the buffer and the address counter.
REQ-006 Port: in_valid  in  1  request valid.
REQ-007 Port: in_ready  out  1  request may be accepted this cycle.
REQ-008 Port: in_class  in  3  instruction class: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J; 6 and 7 are invalid.
REQ-009 Port: in_rs, in_rt, in_rd, in_funct  in  3 each  register and funct fields.
REQ-010 Port: in_imm  in  6  two's-complement immediate.
REQ-011 Port: in_target  in  12  jump target.
REQ-012 Port: out_valid  out  1  encoded word available.
REQ-013 Port: out_ready  in  1  consumer (instruction-memory writer) accepts the word.
REQ-014 Port: out_instr  out  16  encoded instruction at the buffer head.
REQ-015 Port: out_addr  out  ADDR_W  word address for out_instr.
REQ-016 Port: err  out  1  sticky flag: an invalid class was accepted.
REQ-017 Port: err_count  out  4  count of invalid requests, saturating at 15.

Function
REQ-018 Opcode per class SHALL be: R 0000, ADDI 0100, LW 1011, SW 1111, BEQ 1000, J 0010.
REQ-019 The R-type encoding SHALL be {op, rs, rt, rd, funct}.
REQ-020 The ADDI, LW, SW and BEQ encodings SHALL be {op, rs, rt, imm[5:0]}.
REQ-021 The J encoding SHALL be {op, target[11:0]}.
REQ-022 A request SHALL be accepted on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-023 in_ready SHALL equal (buffer not full) and SHALL be registered-state only, with no combinational path from out_ready.
REQ-024 An accepted valid-class request SHALL be encoded and written to the buffer tail in the same edge.
REQ-025 An accepted invalid class (6 or 7) SHALL complete the handshake, write nothing to the buffer, set err, and increment err_count (saturating at 15).
REQ-026 out_valid SHALL equal (buffer not empty); out_instr SHALL be the head entry.
REQ-027 There SHALL be no bypass: a word accepted at edge N is first visible at the output after edge N, giving a minimum latency of 1 cycle.
REQ-028 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_addr SHALL then increment by 1 and wrap from 2^ADDR_W-1 to 0.
REQ-029 out_addr SHALL hold the address of the current head word and SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 On a simultaneous push and pop, occupancy SHALL be unchanged and both SHALL take effect.
REQ-031 When full, in_ready SHALL be 0, even if a pop occurs on the same edge; the freed slot becomes usable on the next cycle.
REQ-032 out_instr and out_addr SHALL hold their values while out_valid=1 and out_ready=0.
REQ-033 flush=1 SHALL empty the buffer, zero out_addr and block acceptance and pops on that edge; err and err_count SHALL be unaffected.

Reset
REQ-034 When reset_n=0, asynchronously: buffer empty, out_valid=0, in_ready=0, out_addr=0, out_instr=0, err=0, err_count=0.
REQ-035 in_ready SHALL rise on the first rising clk edge after reset_n deasserts.
REQ-036 Reset asserted mid-transfer SHALL discard all buffered words, with no partial pop.

Verification
REQ-037 ADDI rs=1 rt=2 imm=5, then R rs=1 rt=2 rd=3 funct=2, out_ready=1 -> 0x4285 @ addr 0, then 0x029A @ addr 1.
REQ-038 J target=0x123; LW rs=0 rt=3 imm=-1; SW rs=7 rt=7 imm=0; BEQ rs=1 rt=1 imm=-2 -> 0x2123, 0xB0FF, 0xFFC0, 0x827E at consecutive addresses.
REQ-039 out_ready=0, 5 back-to-back requests -> in_ready=0 after 4; the 5th is held until a pop, then in_ready returns to 1 the cycle after the pop; no word is lost or duplicated.
REQ-040 in_class=6 sent 17 times -> no out_valid, err=1, err_count=15.
REQ-041 Pre-load out_addr=255, pop 2 words -> addresses 255 then 0.
REQ-042 Flush with 3 words buffered -> out_valid=0 next cycle, out_addr=0, err unchanged; reset_n pulsed mid-stream -> all outputs reset immediately, without waiting for a clock edge.
